cache_fill_arbiter: RTL
=======================

# cache_fill_arbiter

Shares the single multi-cycle main memory between the instruction-cache miss path, the data-cache miss path and write-through stores. It serializes the requests and sequences 8-word block fills with pipelined read issue. It produces the per-cache fill strobes and the stall signals that freeze the IF and MEM stages. It sits between the two caches and the 4-cycle main memory model.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- BLK_WORDS, 8, words per cache block (16-byte block)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_miss  in  1  I-cache miss request, level, held until i_fill_done
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache miss request, level, held until d_fill_done
- d_miss_addr  in  16  D-cache miss byte address
- d_wr  in  1  write-through store request, level, held until d_wr_done
- d_wr_addr  in  16  store address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  read data valid
- fill_data  out  16  equals mem_rdata
- fill_word  out  3  word index within block being filled
- i_fill_we  out  1  write fill_data into I-cache data array
- d_fill_we  out  1  write fill_data into D-cache data array
- i_fill_done  out  1  one-cycle pulse: I block complete, write tag/valid
- d_fill_done  out  1  one-cycle pulse: D block complete, write tag/valid
- d_wr_done  out  1  one-cycle pulse: store accepted by memory
- i_stall  out  1  freeze IF
- d_stall  out  1  freeze MEM and earlier

## Operation
- States: IDLE, WRITE, FILL, DONE.
- IDLE: grant is by fixed priority, d_wr > d_miss > i_miss.
  - Grant to d_wr -> WRITE. Grant to a miss -> FILL.
  - On a miss grant: latch block base = miss_addr[15:4] and owner (I/D). Clear issue_cnt and recv_cnt.
- WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_done=1 -> IDLE.
- FILL issue side:
  - While issue_cnt < 8: mem_en=1, mem_wr=0, mem_addr={base, issue_cnt[2:0], 1'b0}, then issue_cnt++.
  - Once issue_cnt = 8: mem_en=0.
- FILL receive side:
  - On each mem_rvalid: fill_word=recv_cnt[2:0], the owner's fill_we=1, then recv_cnt++.
  - When recv_cnt = 8 -> DONE.
- DONE (1 cycle): the owner's fill_done=1 -> IDLE.
- i_stall = i_miss & ~i_fill_done.
- d_stall = (d_miss & ~d_fill_done) | (d_wr & ~d_wr_done).
- Both stalls are combinational from the inputs and the registered state.

## Timing
- Reset value of every output and register: 0. State = IDLE; counters 0.
- Grant latency: a request seen in IDLE at cycle 0 enters WRITE/FILL at cycle 1.
- Fill with 4-cycle memory:
  - Issues at cycles 1–8.
  - Data at cycles 5–12.
  - DONE at cycle 13; fill_done pulses in cycle 13.
  - Back to IDLE in cycle 14. A new grant can be made in cycle 14.
- A store takes 2 cycles: grant in cycle 0, WRITE in cycle 1.
- Simultaneous requests: i_miss and d_miss asserted together -> D is filled first. I keeps i_stall=1 and is granted in the IDLE cycle after DONE.
- d_wr while an I fill is in progress: waits with d_stall=1, granted at the next IDLE.
- Request dropped mid-fill: the fill still completes. The done pulse is still issued.
- mem_rvalid outside FILL, or after recv_cnt = 8: ignored, no fill_we.
- Reset mid-fill: IDLE next cycle, all counters cleared. Late mem_rvalid pulses are ignored; no partial fill_done.
- fill_word range is 0–7. Counters are 4 bits wide so that the value 8 is representable.

## Structure
- Shared package cache_pkg:
  - state enum {IDLE, WRITE, FILL, DONE}
  - BLK_WORDS, BLK_OFF_W=4, WORD_IDX_W=3
  - owner encoding (OWN_I=0, OWN_D=1)
- Sub-module blk_word_counter: 4-bit counter with clr, inc and done (== BLK_WORDS) outputs. It is instantiated twice, as issue_cnt and recv_cnt.

## Test plan
- Lone I miss at 0x1234, memory latency 4:
  - mem_addr sequence 0x1230, 0x1232 … 0x123E in cycles 1–8.
  - i_fill_we in cycles 5–12 with fill_word 0–7.
  - i_fill_done only in cycle 13.
  - i_stall falls in cycle 13.
- i_miss (0x0040) and d_miss (0x2000) together:
  - D addresses 0x2000–0x200E are issued first, then d_fill_done.
  - I issues start in the cycle after the IDLE that follows DONE.
  - i_stall=1 throughout.
- d_wr (0x3000, 0xBEEF) with d_miss in the same cycle:
  - WRITE in cycle 1 with mem_wr=1, mem_wdata=0xBEEF.
  - d_wr_done=1 in cycle 1.
  - D fill is granted at cycle 2 and starts issuing at cycle 3.
- Reset asserted at cycle 6 of an I fill:
  - All outputs 0 in cycle 7.
  - mem_rvalid pulses in cycles 7–12 produce no fill_we and no fill_done.
- Extra mem_rvalid after the 8th word, and mem_rvalid in IDLE: no fill strobes, state unchanged.
- d_miss dropped at cycle 3 of a D fill: all 8 d_fill_we strobes still occur and d_fill_done still pulses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill arbiter: FSM states, fill owner and grant encodings.
// The block geometry is 8 words of 16 bits per block. The counters are 4 bits so that "8 words seen" is representable.
package cache_pkg;

  localparam int BLK_WORDS  = 8;
  localparam int BLK_OFF_W  = 4;
  localparam int WORD_IDX_W = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_D    = 2'd2,
    GNT_I    = 2'd3
  } grant_e;

  // Fixed priority: stores first, so the write-through path never starves behind fills.
  function automatic grant_e pick_grant(input logic wr, input logic d_req, input logic i_req);
    grant_e g;
    if (wr)         g = GNT_WR;
    else if (d_req) g = GNT_D;
    else if (i_req) g = GNT_I;
    else            g = GNT_NONE;
    return g;
  endfunction

endpackage

// File: rtl/blk_word_counter.sv
// Word counter for one block transfer. It saturates at LIMIT, and done_o flags LIMIT.
// Latency: the count updates on the clock edge. A clear takes priority over an increment.
module blk_word_counter
  import cache_pkg::*;
#(
  parameter int LIMIT = BLK_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = (cnt_q == CNT_W'(LIMIT));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Serializes I-miss fills, D-miss fills and write-through stores onto one pipelined memory port.
// A grant lands one cycle after the request. Requesters are held off through the i_stall and d_stall outputs.
module cache_fill_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_done,
  output logic              i_stall,
  output logic              d_stall
);

  import cache_pkg::*;

  localparam int BASE_W = ADDR_W - BLK_OFF_W;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [BASE_W-1:0] base_q, base_d;

  grant_e            grant;
  logic              cnt_clr;
  logic              issue_inc;
  logic              issue_done;
  logic              recv_done;
  logic              accept;
  logic              last_word;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic              unused_bits;

  assign grant     = (state_q == IDLE) ? pick_grant(d_wr, d_miss, i_miss) : GNT_NONE;
  assign cnt_clr   = (grant == GNT_D) || (grant == GNT_I);
  assign issue_inc = (state_q == FILL) && !issue_done;
  // Returns beyond the eighth word, or outside FILL, are dropped here.
  assign accept    = (state_q == FILL) && mem_rvalid && !recv_done;
  assign last_word = accept && (recv_cnt == CNT_W'(BLK_WORDS - 1));

  blk_word_counter #(.LIMIT(BLK_WORDS)) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (issue_inc),
    .cnt_o  (issue_cnt),
    .done_o (issue_done)
  );

  blk_word_counter #(.LIMIT(BLK_WORDS)) u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (accept),
    .cnt_o  (recv_cnt),
    .done_o (recv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        case (grant)
          GNT_WR: state_d = WRITE;
          GNT_D: begin
            state_d = FILL;
            owner_d = OWN_D;
            base_d  = d_miss_addr[ADDR_W-1:BLK_OFF_W];
          end
          GNT_I: begin
            state_d = FILL;
            owner_d = OWN_I;
            base_d  = i_miss_addr[ADDR_W-1:BLK_OFF_W];
          end
          default: state_d = IDLE;
        endcase
      end
      WRITE:   state_d = IDLE;
      FILL:    if (last_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;
    case (state_q)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_done = 1'b1;
      end
      FILL: begin
        if (!issue_done) begin
          mem_en   = 1'b1;
          mem_addr = {base_q, issue_cnt[WORD_IDX_W-1:0], 1'b0};
        end
        if (accept) begin
          fill_word = recv_cnt[WORD_IDX_W-1:0];
          if (owner_q == OWN_D) d_fill_we = 1'b1;
          else                  i_fill_we = 1'b1;
        end
      end
      DONE: begin
        if (owner_q == OWN_D) d_fill_done = 1'b1;
        else                  i_fill_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign fill_data = mem_rdata;
  assign i_stall   = i_miss & ~i_fill_done;
  assign d_stall   = (d_miss & ~d_fill_done) | (d_wr & ~d_wr_done);

  // Block offset bits and counter MSBs carry no information on this path.
  assign unused_bits = ^{i_miss_addr[BLK_OFF_W-1:0], d_miss_addr[BLK_OFF_W-1:0],
                         issue_cnt[CNT_W-1], recv_cnt[CNT_W-1]};

endmodule
